// File: rtl/ov7670_config_sequencer.sv
// rtl/ov7670_config_sequencer.sv - walks the OV7670 init ROM and issues one SCCB write per entry
// Reserved words: FFF0 inserts a DELAY_CYCLES pause, FFFF ends the table.
module ov7670_config_sequencer #(
   parameter int unsigned DELAY_CYCLES = 1_000_000,
   parameter int unsigned CNT_W        = 24
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   output logic [7:0]  rom_addr_o,
   input  logic [15:0] rom_data_i,
   output logic        sccb_start_o,
   output logic [7:0]  sccb_addr_o,
   output logic [7:0]  sccb_data_o,
   input  logic        sccb_ready_i,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, SEND, WAIT_LO, WAIT_HI, DELAY, FINISH
   } state_t;

   localparam logic [15:0]      WORD_DELAY = 16'hFFF0;
   localparam logic [15:0]      WORD_END   = 16'hFFFF;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DELAY_CYCLES - 1);

   state_t           state_q;
   logic [7:0]       rom_addr_q;
   logic [7:0]       sccb_addr_q;
   logic [7:0]       sccb_data_q;
   logic             sccb_start_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             advance;

   // An entry is retired either when its write handshake completes or its pause expires.
   assign advance = ((state_q == WAIT_HI) && sccb_ready_i) ||
                    ((state_q == DELAY) && (cnt_q == CNT_LAST));
   assign cnt_d   = cnt_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         rom_addr_q   <= 8'd0;
         sccb_addr_q  <= 8'd0;
         sccb_data_q  <= 8'd0;
         sccb_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sccb_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  rom_addr_q <= 8'd0;
                  done_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= FETCH;
               end
            end
            FETCH:  state_q <= DECODE;
            DECODE: begin
               if (rom_data_i == WORD_END) begin
                  state_q <= FINISH;
               end else if (rom_data_i == WORD_DELAY) begin
                  cnt_q   <= '0;
                  state_q <= DELAY;
               end else begin
                  sccb_addr_q <= rom_data_i[15:8];
                  sccb_data_q <= rom_data_i[7:0];
                  state_q     <= SEND;
               end
            end
            SEND: begin
               if (sccb_ready_i) begin
                  sccb_start_q <= 1'b1;
                  state_q      <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (!sccb_ready_i) state_q <= WAIT_HI;
            end
            WAIT_HI: ;
            DELAY: begin
               if (cnt_q != CNT_LAST) cnt_q <= cnt_d;
            end
            FINISH: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // The table never wraps: the last ROM slot always finishes the sequence.
         if (advance) begin
            if (rom_addr_q == 8'hFF) begin
               state_q <= FINISH;
            end else begin
               rom_addr_q <= rom_addr_q + 1'b1;
               state_q    <= FETCH;
            end
         end
      end
   end

   assign rom_addr_o   = rom_addr_q;
   assign sccb_start_o = sccb_start_q;
   assign sccb_addr_o  = sccb_addr_q;
   assign sccb_data_o  = sccb_data_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule
